// File: rtl/powlib_bus_pkg.sv
// powlib_bus_pkg
//   Shared definitions for the powlib bus responder slice.
//   - ERRCNT_W     : width of the dropped-request counter
//   - rsp_state_e  : responder FSM encoding (IDLE, RDMEM, RESP)
//   - sat_inc()    : saturating increment used by the error counter
package powlib_bus_pkg;

  localparam int ERRCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RDMEM = 2'd1,
    ST_RESP  = 2'd2
  } rsp_state_e;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == '1) ? v : v + ERRCNT_W'(1);
  endfunction

endpackage

// File: rtl/powlib_busrsp_ram.sv
// powlib_busrsp_ram
//   DEPTH x DW single-clock memory with one write port and one
//   synchronous read port. When a read and a write hit the same word in
//   the same cycle, the read returns the data being written.
//   Ports:
//     clk      in   clock
//     wr_en    in   write enable
//     wr_addr  in   write word address
//     wr_data  in   write data
//     rd_en    in   read enable (rd_data updates only when set)
//     rd_addr  in   read word address
//     rd_data  out  registered read data
//   Contents are never cleared; there is deliberately no reset.
module powlib_busrsp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;

  // Read data selection: bypass the array when the same word is being
  // written this cycle so the reader sees the new value.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  // Storage array and read register share the clock; neither is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/powlib_busrsp.sv
// powlib_busrsp
//   Memory-backed bus responder. Requests at BASE..BASE+DEPTH-1 write
//   rddata into memory; requests at BASE+DEPTH..BASE+2*DEPTH-1 read the
//   aliased word and send it back to the address carried in
//   rddata[B_AW-1:0]. Anything else is dropped.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   synchronous active-high reset
//     rddata  in   request data / return address
//     rdaddr  in   request address
//     rdvld   in   request valid
//     rdrdy   out  request ready (IDLE only)
//     wrdata  out  response data
//     wraddr  out  response destination address
//     wrvld   out  response valid
//     wrrdy   in   response ready
//     errcnt  out  saturating count of dropped requests
//   Build option: define POWLIB_BUSRSP_ERRCNT_EN to enable the errcnt
//   counter; otherwise errcnt is tied to zero and drops are silent.
module powlib_busrsp
  import powlib_bus_pkg::*;
#(
  parameter int              B_AW  = 16,
  parameter int              B_DW  = 32,
  parameter logic [B_AW-1:0] BASE  = 16'h0000,
  parameter int              DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [B_DW-1:0]     rddata,
  input  logic [B_AW-1:0]     rdaddr,
  input  logic                rdvld,
  output logic                rdrdy,
  output logic [B_DW-1:0]     wrdata,
  output logic [B_AW-1:0]     wraddr,
  output logic                wrvld,
  input  logic                wrrdy,
  output logic [ERRCNT_W-1:0] errcnt
);

  localparam int              AW     = $clog2(DEPTH);
  // One extra bit so 2*DEPTH == 2**B_AW is still representable.
  localparam logic [B_AW:0]   LIM_WR = (B_AW+1)'(DEPTH);
  localparam logic [B_AW:0]   LIM_RD = (B_AW+1)'(2*DEPTH);

  rsp_state_e      state_q, state_d;
  logic            wrvld_q, wrvld_d;
  logic [B_AW-1:0] wraddr_q, wraddr_d;
  logic [B_DW-1:0] wrdata_q, wrdata_d;

  logic [B_AW-1:0] off;
  logic            wr_hit;
  logic            rd_hit;
  logic            accept;
  logic [B_DW-1:0] ram_rd_data;

  // Address decode. The read window aliases the write window, and since
  // DEPTH is a power of two the low AW bits of off already index the
  // right word for both.
  always_comb begin
    off    = rdaddr - BASE;
    wr_hit = ({1'b0, off} < LIM_WR);
    rd_hit = !wr_hit && ({1'b0, off} < LIM_RD);
  end

  // Ready is combinational on state so the first cycle out of reset can
  // already accept; it is forced low while rst is asserted.
  assign rdrdy  = (state_q == ST_IDLE) && !rst;
  assign accept = rdvld && rdrdy;

  powlib_busrsp_ram #(
    .DW    (B_DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept && wr_hit),
    .wr_addr (off[AW-1:0]),
    .wr_data (rddata),
    .rd_en   (accept && rd_hit),
    .rd_addr (off[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  // Next-state logic. A read captures its return address at accept,
  // the RAM word is ready during RDMEM and is latched into wrdata on the
  // way into RESP, where it is held until the sink takes it.
  always_comb begin
    state_d  = state_q;
    wrvld_d  = wrvld_q;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && rd_hit) begin
          state_d  = ST_RDMEM;
          wraddr_d = rddata[B_AW-1:0];
        end
      end
      ST_RDMEM: begin
        state_d  = ST_RESP;
        wrvld_d  = 1'b1;
        wrdata_d = ram_rd_data;
      end
      ST_RESP: begin
        if (wrrdy) begin
          state_d = ST_IDLE;
          wrvld_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wrvld_d = 1'b0;
      end
    endcase
  end

  // FSM and registered response outputs. Reset abandons any read in
  // flight; memory contents live in the RAM and survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wrvld_q  <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wrvld_q  <= wrvld_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
    end
  end

  assign wrvld  = wrvld_q;
  assign wraddr = wraddr_q;
  assign wrdata = wrdata_q;

`ifdef POWLIB_BUSRSP_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  // Count accepted requests that hit neither window.
  always_comb begin
    errcnt_d = errcnt_q;
    if (accept && !wr_hit && !rd_hit) begin
      errcnt_d = sat_inc(errcnt_q);
    end
  end

  // Error counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign errcnt = errcnt_q;
`else
  assign errcnt = '0;
`endif

endmodule

// File: tb/tb_powlib_busrsp.sv
// tb_powlib_busrsp
//   Directed bench for powlib_busrsp (BASE=16'h4000, DEPTH=256).
//   Stimulus pushes hand-computed responses into a queue; a monitor on
//   the falling edge pops and compares whenever wrvld is seen.
module tb_powlib_busrsp;

  logic        clk;
  logic        rst;
  logic [31:0] rddata;
  logic [15:0] rdaddr;
  logic        rdvld;
  logic        rdrdy;
  logic [31:0] wrdata;
  logic [15:0] wraddr;
  logic        wrvld;
  logic        wrrdy;
  logic [7:0]  errcnt;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  bit   in_rsp = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef POWLIB_BUSRSP_ERRCNT_EN
  localparam logic [7:0] EXP_ERR2   = 8'd2;
  localparam logic [7:0] EXP_ERRSAT = 8'd255;
`else
  localparam logic [7:0] EXP_ERR2   = 8'd0;
  localparam logic [7:0] EXP_ERRSAT = 8'd0;
`endif

  powlib_busrsp #(
    .B_AW  (16),
    .B_DW  (32),
    .BASE  (16'h4000),
    .DEPTH (256)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rddata (rddata),
    .rdaddr (rdaddr),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .wrdata (wrdata),
    .wraddr (wraddr),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .errcnt (errcnt)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something never returns.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one request and hold it until accepted. If a response is
  // expected, its return address and data are queued for the monitor.
  task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d,
                               input bit exp_rsp, input logic [31:0] exp_data);
    int   n;
    exp_t e;
    n      = 0;
    rdaddr = a;
    rddata = d;
    rdvld  = 1'b1;
    #1;
    while (rdrdy !== 1'b1 && n < 100) begin
      tick();
      #1;
      n++;
    end
    if (rdrdy !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: rdrdy=%b, expected 1 within 100 cycles", rdrdy);
      rdvld = 1'b0;
      return;
    end
    if (exp_rsp) begin
      e.addr = d[15:0];
      e.data = exp_data;
      e.acc  = cyc;
      exp_q.push_back(e);
    end
    tick();
    rdvld  = 1'b0;
    // Junk on the idle bus must not reach memory.
    rdaddr = 16'h4010;
    rddata = 32'hBAD0BAD0;
  endtask

  // Wait until all queued responses are delivered and wrvld is low.
  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wrvld !== 1'b0 || in_rsp) && n < 100) begin
      tick();
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
  endtask

  // Response monitor: compare every response cycle against the queued
  // expectation, including hold under backpressure and read latency.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      in_rsp = 0;
    end else if (wrvld === 1'b1) begin
      if (!in_rsp) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: wraddr=%h wrdata=%h, expected no response", wraddr, wrdata);
          cur_e.addr = wraddr;
          cur_e.data = wrdata;
        end else begin
          cur_e = exp_q.pop_front();
          checkOutput("rsp_latency", cyc - cur_e.acc, 2);
        end
        in_rsp = 1;
      end
      checkOutput("rsp_addr", wraddr, cur_e.addr);
      checkOutput("rsp_data", wrdata, cur_e.data);
      checkOutput("rdrdy_in_rsp", rdrdy, 0);
      if (wrrdy === 1'b1) in_rsp = 0;
    end
  end

  initial begin
    int n;
    rst    = 1'b1;
    rdvld  = 1'b0;
    rdaddr = '0;
    rddata = '0;
    wrrdy  = 1'b1;

    // Reset values.
    repeat (3) tick();
    #1;
    checkOutput("rst_wrvld", wrvld, 0);
    checkOutput("rst_wraddr", wraddr, 0);
    checkOutput("rst_wrdata", wrdata, 0);
    checkOutput("rst_errcnt", errcnt, 0);
    checkOutput("rst_rdrdy", rdrdy, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_rdrdy", rdrdy, 1);
    tick();

    // Basic write then read back.
    applyStimulus(16'h4010, 32'hDEADBEEF, 0, '0);
    applyStimulus(16'h4110, 32'h00000123, 1, 32'hDEADBEEF);
    waitIdle();

    // Backpressure: sink stalls for 5 cycles in RESP.
    applyStimulus(16'h4020, 32'h11223344, 0, '0);
    wrrdy = 1'b0;
    applyStimulus(16'h4120, 32'h00000BEE, 1, 32'h11223344);
    n = 0;
    while (wrvld !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("bp_wrvld", wrvld, 1);
      checkOutput("bp_rdrdy", rdrdy, 0);
      tick();
    end
    wrrdy = 1'b1;
    waitIdle();

    // Window edges: last word, and the first read alias of word 0.
    applyStimulus(16'h40FF, 32'hCAFEF00D, 0, '0);
    applyStimulus(16'h41FF, 32'h000000FF, 1, 32'hCAFEF00D);
    applyStimulus(16'h4000, 32'hA5A50000, 0, '0);
    applyStimulus(16'h4100, 32'h00000001, 1, 32'hA5A50000);
    waitIdle();

    // Out of range above and below: dropped, memory untouched.
    applyStimulus(16'h4200, 32'h12345678, 0, '0);
    applyStimulus(16'h3FFF, 32'h87654321, 0, '0);
    repeat (3) tick();
    checkOutput("errcnt_2", errcnt, EXP_ERR2);
    applyStimulus(16'h4100, 32'h00000002, 1, 32'hA5A50000);
    applyStimulus(16'h41FF, 32'h00000003, 1, 32'hCAFEF00D);
    waitIdle();

    // 256 more dropped requests back to back: counter saturates.
    rdvld = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rdaddr = 16'h5000 + 16'(i);
      rddata = 32'(i);
      tick();
    end
    rdvld = 1'b0;
    #1;
    checkOutput("errcnt_sat", errcnt, EXP_ERRSAT);
    tick();

    // Back-to-back writes with rdvld held high.
    rdvld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdaddr = 16'h4030 + 16'(i);
      rddata = 32'h10000000 + 32'(i);
      #1;
      checkOutput("b2b_rdrdy", rdrdy, 1);
      tick();
    end
    rdvld = 1'b0;
    applyStimulus(16'h4130, 32'h00000030, 1, 32'h10000000);
    applyStimulus(16'h4131, 32'h00000031, 1, 32'h10000001);
    applyStimulus(16'h4132, 32'h00000032, 1, 32'h10000002);
    applyStimulus(16'h4133, 32'h00000033, 1, 32'h10000003);
    waitIdle();

    // Reset while in RDMEM: no response, ready right after, data kept.
    applyStimulus(16'h4050, 32'h5555AAAA, 0, '0);
    applyStimulus(16'h4150, 32'h00000055, 0, '0);
    rst = 1'b1;
    #1;
    checkOutput("rdmem_wrvld", wrvld, 0);
    tick();
    #1;
    checkOutput("rst_mid_rdrdy", rdrdy, 0);
    checkOutput("rst_mid_wrvld", wrvld, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_drop_rdrdy", rdrdy, 1);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("abandon_wrvld", wrvld, 0);
      tick();
    end
    applyStimulus(16'h4150, 32'h00000056, 1, 32'h5555AAAA);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/powlib_busrsp.md
POWLIB_BUSRSP -- requirements
Module: powlib_busrsp

Interface
REQ-001 SHALL have parameter B_AW, default 16, bus address width.
REQ-002 SHALL have parameter B_DW, default 32, bus data width (B_DW >= B_AW).
REQ-003 SHALL have parameter BASE, default 16'h0000, first bus address owned by this responder.
REQ-004 SHALL have parameter DEPTH, default 256, memory words; power of two, 2*DEPTH <= 2**B_AW.
REQ-005 SHALL have port clk  in  1  clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port rddata  in  B_DW  request data (write word, or return address in [B_AW-1:0]).
REQ-008 SHALL have port rdaddr  in  B_AW  request address.
REQ-009 SHALL have port rdvld  in  1  request valid.
REQ-010 SHALL have port rdrdy  out  1  request ready.
REQ-011 SHALL have port wrdata  out  B_DW  response data.
REQ-012 SHALL have port wraddr  out  B_AW  response destination address.
REQ-013 SHALL have port wrvld  out  1  response valid.
REQ-014 SHALL have port wrrdy  in  1  response ready.
REQ-015 SHALL have port errcnt  out  8  count of dropped out-of-range requests.

Function
REQ-016 SHALL treat a request as accepted only in a cycle with rdvld && rdrdy.
REQ-017 SHALL compute off = rdaddr - BASE, modulo 2**B_AW.
REQ-018 SHALL, for off < DEPTH, write rddata to mem[off] at the accepting edge, staying in IDLE.
REQ-019 SHALL, for DEPTH <= off < 2*DEPTH, treat it as a read of mem[off-DEPTH], capturing rddata[B_AW-1:0] as the return address.
REQ-020 SHALL, for off >= 2*DEPTH, drop the request and increment errcnt, saturating at 255.
REQ-021 SHALL implement FSM IDLE -> RDMEM (read accepted) -> RESP (one cycle later) -> IDLE (wrvld && wrrdy).
REQ-022 SHALL drive rdrdy = 1 only in IDLE and not in reset.
REQ-023 SHALL assert wrvld only in RESP, holding wraddr/wrdata stable until wrrdy.
REQ-024 SHALL drive wraddr = captured return address and wrdata = mem word read in RDMEM.
REQ-025 SHALL give read latency of exactly 2 cycles from accept edge to first wrvld high.
REQ-026 SHALL return the newly written value for a write followed by a read to the same word on the next accept.
REQ-027 SHALL be unaffected by rddata/rdaddr values when rdvld is low.

Reset
REQ-028 SHALL, on rst, set FSM to IDLE, wrvld = 0, wraddr = 0, wrdata = 0, errcnt = 0, rdrdy = 0.
REQ-029 SHALL abandon any read in RDMEM/RESP on rst mid-operation with no response issued.
REQ-030 SHALL NOT clear memory contents on rst.

Configuration
REQ-031 SHALL, with POWLIB_BUSRSP_ERRCNT_EN defined, implement the errcnt counter per REQ-020.
REQ-032 SHALL, without POWLIB_BUSRSP_ERRCNT_EN, tie errcnt to 0 and still drop out-of-range requests silently.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE, RDMEM, RESP) and errcnt width constant in shared package powlib_bus_pkg.
REQ-034 SHALL instantiate one sub-module powlib_busrsp_ram: DEPTH x B_DW, one write port, one synchronous read port, write-before-read on collision.

Verification (BASE=16'h4000, DEPTH=256)
REQ-035 SHALL check a write of 32'hDEADBEEF to 16'h4010, then a read request to 16'h4110 with data 16'h0123 -> wraddr=16'h0123, wrdata=32'hDEADBEEF, wrvld high 2 cycles after accept.
REQ-036 SHALL check backpressure: hold wrrdy=0 for 5 cycles in RESP -> wrvld stays high, outputs stable, rdrdy=0 throughout.
REQ-037 SHALL check out-of-range: requests to 16'h4200 and 16'h3FFF -> no memory change, no response, errcnt=2; 256 such requests -> errcnt=255.
REQ-038 SHALL check boundaries: write to 16'h40FF and read via 16'h41FF -> data returned; request to 16'h4100 reads word 0.
REQ-039 SHALL check reset in RDMEM -> wrvld never asserts, rdrdy=1 in the first cycle after rst drops, and a prior write remains readable.
REQ-040 SHALL check back-to-back writes with rdvld held high -> one accept per cycle, all 4 words readable afterwards.
